mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
- Parametrised next-generation counter: configurable width, modulus, reset value, and wrap or saturate mode.
- Features: up/down direction, synchronous load, synchronous clear, enable, registered wrap/limit event outputs, and a sticky overflow flag.
- Used as a general-purpose event/timer counter in datapath and control blocks where the previous fixed 4-bit load/enable counter is too narrow or lacks modulus and direction control.

Parameters:
- WIDTH, 8, counter bit width (>=2).
- MAX_VAL, 2**WIDTH-1, terminal count. The counter range is 0..MAX_VAL; legal values are 1 <= MAX_VAL <= 2**WIDTH-1.
- RESET_VAL, 0, value of q at reset and after clr; must be <= MAX_VAL.
- SATURATE, 0, limit behaviour: 0 = wrap at limits, 1 = hold at limits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous clear to RESET_VAL.
- load  input  1  synchronous load of d.
- d  input  WIDTH  load data.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- q  output  WIDTH  registered count value.
- at_max  output  1  combinational: q == MAX_VAL.
- at_min  output  1  combinational: q == 0.
- wrap  output  1  registered one-cycle pulse when a limit event occurs.
- ovf_sticky  output  1  registered sticky flag, set by any wrap pulse.

Behaviour:
- Reset (reset low, asynchronous, at any time including mid-count):
  - q = RESET_VAL, wrap = 0, ovf_sticky = 0.
  - Deassertion is synchronous-safe: the first count occurs on the first rising edge with reset high.
- Priority at each rising edge: clr > load > en. With none of them active, q holds and wrap = 0.
- clr:
  - q <= RESET_VAL, wrap <= 0, ovf_sticky <= 0.
  - clr overrides a simultaneous load and en.
- load:
  - q <= d when d <= MAX_VAL, otherwise q <= MAX_VAL (clamped).
  - wrap <= 0; ovf_sticky unchanged.
  - load overrides a simultaneous en, so no count occurs that cycle.
- en with up = 1:
  - q < MAX_VAL: q <= q + 1.
  - q == MAX_VAL, SATURATE = 0: q <= 0.
  - q == MAX_VAL, SATURATE = 1: q holds.
- en with up = 0:
  - q > 0: q <= q - 1.
  - q == 0, SATURATE = 0: q <= MAX_VAL.
  - q == 0, SATURATE = 1: q holds.
- Limit events and wrap:
  - A limit event is en active with no clr/load while at_max&up or at_min&!up, in either SATURATE mode.
  - On that edge wrap <= 1; on every other edge wrap <= 0.
  - wrap is high during exactly the cycle in which q shows the post-event value (wrapped or held).
  - Back-to-back events in saturate mode give wrap high for consecutive cycles.
- ovf_sticky <= 1 on any limit event; it is cleared only by reset or clr.
- Latency: one clock from sampled inputs to q/wrap. at_max/at_min follow q combinationally, with no added latency.
- Arithmetic is performed at WIDTH+1 bits internally. When MAX_VAL = 2**WIDTH-1, the non-saturating wrap equals natural modulo-2**WIDTH rollover.
- A direction change takes effect on the same edge as sampled; there is no turnaround cycle.
- q never leaves 0..MAX_VAL under any input sequence; the bench asserts this every cycle.

Test Plan:
1. Reset/load (defaults, WIDTH=8): hold reset low 2 cycles, release, load=1 d=8'hAA for 1 cycle -> q=8'h00 during reset, q=8'hAA after next edge, wrap=0, ovf_sticky=0.
2. Full up sweep (defaults): from q=8'hAA, en=1 up=1 for 256 cycles -> q matches a model each cycle; q goes 8'hFF->8'h00 with wrap=1 for exactly that cycle; ovf_sticky=1 afterward; final q=8'hAA.
3. Modulo-10 down count (MAX_VAL=9, WIDTH=4, SATURATE=0): load 4'd2, en=1 up=0 for 4 cycles -> q=1,0,9,8; wrap pulses when q=9; load d=4'd15 -> q=9 (clamped).
4. Saturate mode (MAX_VAL=9, SATURATE=1): load 4'd8, en=1 up=1 for 3 cycles -> q=9,9,9; wrap=0,1,1; at_max=1 from the first cycle; then up=0 for 1 cycle -> q=8, wrap=0.
5. Simultaneous controls (defaults): q=8'h10; assert clr+load+en together -> q=RESET_VAL and ovf_sticky=0; then load+en with d=8'h33 -> q=8'h33, not 8'h34.
6. Reset mid-operation (defaults): counting up at q=8'h40, pull reset low between clock edges -> q=0 and wrap=0 immediately, before the next edge; release -> counting resumes 1,2,3 on the following edges.

Source files
------------

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with modulus, wrap-or-saturate limits, synchronous
// clear/load, a registered limit-event pulse and a sticky overflow flag.
module mod_updown_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int RESET_VAL = 0,
    parameter bit SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap,
    output logic             ovf_sticky
);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);

    logic [WIDTH-1:0] q_reg, q_next;
    logic             wrap_reg, wrap_next;
    logic             ovf_reg, ovf_next;
    logic [WIDTH:0]   inc_ext, dec_ext;
    logic             up_over, dn_under, limit_event;

    // One extra bit lets the limit tests be a compare/borrow, independent of MAX_VAL.
    assign inc_ext  = {1'b0, q_reg} + ONE_EXT;
    assign dec_ext  = {1'b0, q_reg} - ONE_EXT;
    assign up_over  = (inc_ext > MAX_EXT);
    assign dn_under = dec_ext[WIDTH];

    assign limit_event = en & ~clr & ~load & (up ? up_over : dn_under);

    always_comb begin
        q_next    = q_reg;
        wrap_next = limit_event;
        ovf_next  = ovf_reg | limit_event;
        if (clr) begin
            q_next   = RST_Q;
            ovf_next = 1'b0;
        end else if (load) begin
            q_next = ({1'b0, d} > MAX_EXT) ? MAX_Q : d;
        end else if (en) begin
            if (up) begin
                if (up_over) q_next = SATURATE ? q_reg : '0;
                else         q_next = inc_ext[WIDTH-1:0];
            end else begin
                if (dn_under) q_next = SATURATE ? q_reg : MAX_Q;
                else          q_next = dec_ext[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg    <= RST_Q;
            wrap_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            q_reg    <= q_next;
            wrap_reg <= wrap_next;
            ovf_reg  <= ovf_next;
        end
    end

    assign q          = q_reg;
    assign wrap       = wrap_reg;
    assign ovf_sticky = ovf_reg;
    assign at_max     = (q_reg == MAX_Q);
    assign at_min     = (q_reg == '0);
endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: three counter configurations against an arithmetic model,
// directed scenarios first, then randomized control traffic.
module tb_mod_updown_counter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // instance A: defaults (WIDTH=8, MAX=255, wrap)
    logic       a_clr = 0, a_load = 0, a_en = 0, a_up = 0;
    logic [7:0] a_d = 0, a_q;
    logic       a_at_max, a_at_min, a_wrap, a_ovf;
    // instances B (mod-10 wrap) and C (mod-10 saturate, RESET_VAL=3) share inputs
    logic       b_clr = 0, b_load = 0, b_en = 0, b_up = 0;
    logic [3:0] b_d = 0, b_q, c_q;
    logic       b_at_max, b_at_min, b_wrap, b_ovf;
    logic       c_at_max, c_at_min, c_wrap, c_ovf;

    mod_updown_counter u_a (
        .clk(clk), .reset(reset), .clr(a_clr), .load(a_load), .d(a_d), .en(a_en), .up(a_up),
        .q(a_q), .at_max(a_at_max), .at_min(a_at_min), .wrap(a_wrap), .ovf_sticky(a_ovf));
    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0), .SATURATE(1'b0)) u_b (
        .clk(clk), .reset(reset), .clr(b_clr), .load(b_load), .d(b_d), .en(b_en), .up(b_up),
        .q(b_q), .at_max(b_at_max), .at_min(b_at_min), .wrap(b_wrap), .ovf_sticky(b_ovf));
    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(3), .SATURATE(1'b1)) u_c (
        .clk(clk), .reset(reset), .clr(b_clr), .load(b_load), .d(b_d), .en(b_en), .up(b_up),
        .q(c_q), .at_max(c_at_max), .at_min(c_at_min), .wrap(c_wrap), .ovf_sticky(c_ovf));

    int n_chk = 0;
    int n_fail = 0;
    bit checking = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    // Model: a counter over the ring 0..max, with modulo or clamp at the ends.
    task automatic model_step(input int max, input bit sat, input int rv,
                              input bit clr, input bit load, input int dv,
                              input bit en, input bit up,
                              inout int q, inout bit w, inout bit o);
        int t;
        w = 0;
        if (clr) begin
            q = rv;
            o = 0;
        end else if (load) begin
            q = (dv > max) ? max : dv;
        end else if (en) begin
            t = up ? q + 1 : q - 1;
            if (t < 0 || t > max) begin
                w = 1;
                o = 1;
                q = sat ? q : (t + max + 1) % (max + 1);
            end else begin
                q = t;
            end
        end
    endtask

    int ma_q = 0, mb_q = 0, mc_q = 3;
    bit ma_w = 0, ma_o = 0, mb_w = 0, mb_o = 0, mc_w = 0, mc_o = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma_q = 0; ma_w = 0; ma_o = 0;
            mb_q = 0; mb_w = 0; mb_o = 0;
            mc_q = 3; mc_w = 0; mc_o = 0;
        end else begin
            model_step(255, 0, 0, a_clr, a_load, int'(a_d), a_en, a_up, ma_q, ma_w, ma_o);
            model_step(9, 0, 0, b_clr, b_load, int'(b_d), b_en, b_up, mb_q, mb_w, mb_o);
            model_step(9, 1, 3, b_clr, b_load, int'(b_d), b_en, b_up, mc_q, mc_w, mc_o);
        end
    end

    // Compare process: every falling edge, all outputs of all instances.
    always @(negedge clk) begin
        if (checking) begin
            chk("a_q", a_q, ma_q);          chk("a_wrap", a_wrap, ma_w);
            chk("a_ovf", a_ovf, ma_o);      chk("a_at_max", a_at_max, ma_q == 255);
            chk("a_at_min", a_at_min, ma_q == 0);
            chk("b_q", b_q, mb_q);          chk("b_wrap", b_wrap, mb_w);
            chk("b_ovf", b_ovf, mb_o);      chk("b_at_max", b_at_max, mb_q == 9);
            chk("b_at_min", b_at_min, mb_q == 0);
            chk("b_range", b_q <= 4'd9, 1);
            chk("c_q", c_q, mc_q);          chk("c_wrap", c_wrap, mc_w);
            chk("c_ovf", c_ovf, mc_o);      chk("c_at_max", c_at_max, mc_q == 9);
            chk("c_at_min", c_at_min, mc_q == 0);
            chk("c_range", c_q <= 4'd9, 1);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    int wraps;
    initial begin
        #1 checking = 1;
        // 1: reset then load AA
        cyc(); cyc();
        chk("t1_rst_q", a_q, 8'h00); chk("t1_rst_wrap", a_wrap, 0); chk("t1_rst_c_q", c_q, 3);
        reset = 1; a_load = 1; a_d = 8'hAA;
        cyc();
        chk("t1_load_q", a_q, 8'hAA); chk("t1_wrap", a_wrap, 0); chk("t1_ovf", a_ovf, 0);
        // 2: full up sweep
        a_load = 0; a_en = 1; a_up = 1; wraps = 0;
        for (int i = 1; i <= 256; i++) begin
            cyc();
            if (a_wrap) wraps++;
            if (i == 85) chk("t2_ff", a_q, 8'hFF);
            if (i == 86) begin chk("t2_roll", a_q, 8'h00); chk("t2_wrap", a_wrap, 1); end
        end
        chk("t2_wrap_count", wraps, 1); chk("t2_final", a_q, 8'hAA); chk("t2_ovf", a_ovf, 1);
        a_en = 0;
        // 3: modulo-10 down count
        b_load = 1; b_d = 4'd2; cyc();
        b_load = 0; b_en = 1; b_up = 0;
        cyc(); chk("t3_q1", b_q, 1);
        cyc(); chk("t3_q0", b_q, 0); chk("t3_w0", b_wrap, 0);
        cyc(); chk("t3_q9", b_q, 9); chk("t3_w9", b_wrap, 1);
        cyc(); chk("t3_q8", b_q, 8); chk("t3_w8", b_wrap, 0);
        b_en = 0; b_load = 1; b_d = 4'd15; cyc(); chk("t3_clamp", b_q, 9);
        // 4: saturate
        b_d = 4'd8; cyc();
        b_load = 0; b_en = 1; b_up = 1;
        cyc(); chk("t4_q_a", c_q, 9); chk("t4_w_a", c_wrap, 0); chk("t4_max_a", c_at_max, 1);
        cyc(); chk("t4_q_b", c_q, 9); chk("t4_w_b", c_wrap, 1);
        cyc(); chk("t4_q_c", c_q, 9); chk("t4_w_c", c_wrap, 1);
        b_up = 0;
        cyc(); chk("t4_down", c_q, 8); chk("t4_w_d", c_wrap, 0);
        b_en = 0;
        // 5: simultaneous controls
        a_load = 1; a_d = 8'h10; cyc();
        a_clr = 1; a_en = 1; a_d = 8'h55; cyc();
        chk("t5_clr_q", a_q, 0); chk("t5_clr_ovf", a_ovf, 0);
        a_clr = 0; a_d = 8'h33; cyc();
        chk("t5_load_en", a_q, 8'h33);
        // 6: reset between edges
        a_d = 8'h3D; cyc();
        a_load = 0; a_en = 1; a_up = 1;
        cyc(); cyc(); cyc(); chk("t6_at40", a_q, 8'h40);
        @(posedge clk); #2 reset = 0;
        #1 chk("t6_async_q", a_q, 0); chk("t6_async_wrap", a_wrap, 0);
        cyc(); reset = 1;
        cyc(); chk("t6_r1", a_q, 1);
        cyc(); chk("t6_r2", a_q, 2);
        cyc(); chk("t6_r3", a_q, 3);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            a_clr = ($urandom_range(0, 31) == 0); a_load = ($urandom_range(0, 15) == 0);
            a_en = ($urandom_range(0, 3) != 0); a_up = $urandom_range(0, 1) != 0;
            a_d = 8'($urandom_range(0, 255));
            b_clr = ($urandom_range(0, 31) == 0); b_load = ($urandom_range(0, 15) == 0);
            b_en = ($urandom_range(0, 3) != 0); b_up = ($urandom_range(0, 7) < 5);
            b_d = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 199) != 0);
            cyc();
        end
        reset = 1;
        cyc();
        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1, "timeout");
    end
endmodule
